// File: rtl/aes_defs.sv
// Shared definitions for the AES CBC packet sequencer: block type, command
// encodings and FSM state codes.
package aes_defs;

    localparam int BLK_W = 128;

    typedef logic [BLK_W-1:0] blk_t;

    localparam logic [1:0] CMD_ENC = 2'b10;
    localparam logic [1:0] CMD_DEC = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RDREQ   = 3'd1;
    localparam logic [2:0] ST_RDWAIT  = 3'd2;
    localparam logic [2:0] ST_CORE    = 3'd3;
    localparam logic [2:0] ST_COREOUT = 3'd4;
    localparam logic [2:0] ST_WRBACK  = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;
    localparam logic [2:0] ST_WAITLOW = 3'd7;

    // Both encrypt and decrypt have cmd[1] set; anything else is a plain copy.
    function automatic logic is_crypto(input logic [1:0] cmd);
        return cmd[1];
    endfunction

endpackage

// File: rtl/aes_cbc_chain.sv
// CBC chaining state: holds the running chain value and the saved ciphertext,
// and forms the pre-core and post-core XORs for encrypt and decrypt.
module aes_cbc_chain
    import aes_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cmd,
    input  logic       load_iv,
    input  logic       capture_pt,
    input  logic       capture_ct,
    input  blk_t       iv,
    input  blk_t       blk_in,
    input  blk_t       core_out,
    output blk_t       core_blk,
    output blk_t       result_blk
);

    blk_t chain_q, chain_d;
    blk_t ctin_q, ctin_d;

    // The chain always advances to the ciphertext of the block just processed:
    // the core output when encrypting, the block read from SRAM when decrypting.
    always_comb begin
        chain_d = chain_q;
        ctin_d  = ctin_q;
        if (load_iv) begin
            chain_d = iv;
        end else if (capture_ct && is_crypto(cmd)) begin
            chain_d = (cmd == CMD_DEC) ? ctin_q : core_out;
        end
        if (capture_pt && cmd == CMD_DEC) begin
            ctin_d = blk_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
            ctin_q  <= '0;
        end else begin
            chain_q <= chain_d;
            ctin_q  <= ctin_d;
        end
    end

    assign core_blk   = (cmd == CMD_ENC) ? (blk_in ^ chain_q) : blk_in;
    assign result_blk = (cmd == CMD_DEC) ? (core_out ^ chain_q) : core_out;

endmodule

// File: rtl/aes_cbc_seq.sv
// Packet sequencer between genmgr and the AES core: walks one bank of the
// packet SRAM through the core with CBC chaining, writing results in place.
module aes_cbc_seq
    import aes_defs::*;
#(
    parameter int SBASE = 1,
    parameter int NOPKT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             AesIrdy,
    input  logic [SBASE:0]   AesSize,
    input  logic             Sos,
    input  logic             AesBank,
    input  logic [1:0]       Cmd,
    input  logic [127:0]     aes_iv,
    output logic             AesTrdy,
    output logic [SBASE+1:0] buf_addr,
    output logic             buf_rd,
    input  logic [127:0]     buf_rdata,
    output logic             buf_wr,
    output logic [127:0]     buf_wdata,
    output logic             core_irdy,
    output logic [127:0]     core_din,
    input  logic             core_trdy,
    input  logic             core_ovld,
    input  logic [127:0]     core_dout
);

    localparam logic [SBASE:0] PKT_MAX = (SBASE+1)'(NOPKT - 1);
    localparam logic [SBASE:0] PKT_ONE = {{SBASE{1'b0}}, 1'b1};

    logic [2:0]     state_q, state_d;
    logic [SBASE:0] cnt_last_q, cnt_last_d;
    logic [SBASE:0] pkt_q, pkt_d;
    logic           bank_q, bank_d;
    logic [1:0]     cmd_q, cmd_d;
    blk_t           core_din_q, core_din_d;
    blk_t           result_q, result_d;

    logic load_iv;
    logic capture_pt;
    logic capture_ct;
    logic last_pkt;
    blk_t core_blk;
    blk_t result_blk;

    aes_cbc_chain u_chain (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd_q),
        .load_iv    (load_iv),
        .capture_pt (capture_pt),
        .capture_ct (capture_ct),
        .iv         (aes_iv),
        .blk_in     (buf_rdata),
        .core_out   (core_dout),
        .core_blk   (core_blk),
        .result_blk (result_blk)
    );

    // PKT_MAX keeps an out-of-range AesSize from walking past the bank.
    assign last_pkt = (pkt_q == cnt_last_q) || (pkt_q == PKT_MAX);

    always_comb begin
        state_d    = state_q;
        cnt_last_d = cnt_last_q;
        pkt_d      = pkt_q;
        bank_d     = bank_q;
        cmd_d      = cmd_q;
        core_din_d = core_din_q;
        result_d   = result_q;
        load_iv    = 1'b0;
        capture_pt = 1'b0;
        capture_ct = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (AesIrdy) begin
                    cnt_last_d = AesSize;
                    bank_d     = AesBank;
                    cmd_d      = Cmd;
                    pkt_d      = '0;
                    load_iv    = Sos;
                    state_d    = ST_RDREQ;
                end
            end
            ST_RDREQ: begin
                state_d = ST_RDWAIT;
            end
            ST_RDWAIT: begin
                capture_pt = 1'b1;
                if (!is_crypto(cmd_q)) begin
                    result_d = buf_rdata;
                    state_d  = ST_WRBACK;
                end else begin
                    core_din_d = core_blk;
                    state_d    = ST_CORE;
                end
            end
            ST_CORE: begin
                if (core_trdy) begin
                    state_d = ST_COREOUT;
                end
            end
            ST_COREOUT: begin
                if (core_ovld) begin
                    capture_ct = 1'b1;
                    result_d   = result_blk;
                    state_d    = ST_WRBACK;
                end
            end
            ST_WRBACK: begin
                if (last_pkt) begin
                    state_d = ST_DONE;
                end else begin
                    pkt_d   = pkt_q + PKT_ONE;
                    state_d = ST_RDREQ;
                end
            end
            ST_DONE: begin
                state_d = ST_WAITLOW;
            end
            ST_WAITLOW: begin
                // A level request still high from the finished job must not restart us.
                if (!AesIrdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_last_q <= '0;
            pkt_q      <= '0;
            bank_q     <= 1'b0;
            cmd_q      <= 2'b00;
            core_din_q <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_last_q <= cnt_last_d;
            pkt_q      <= pkt_d;
            bank_q     <= bank_d;
            cmd_q      <= cmd_d;
            core_din_q <= core_din_d;
            result_q   <= result_d;
        end
    end

    assign AesTrdy   = (state_q == ST_DONE);
    assign buf_rd    = (state_q == ST_RDREQ);
    assign buf_wr    = (state_q == ST_WRBACK);
    assign core_irdy = (state_q == ST_CORE);
    assign buf_addr  = {bank_q, pkt_q};
    assign buf_wdata = result_q;
    assign core_din  = core_din_q;

endmodule

// File: tb/tb_aes_cbc_seq.sv
// Self-checking bench for aes_cbc_seq: SRAM and AES-core models plus a
// table of directed jobs and hand-written hold/reset sequences.
module tb_aes_cbc_seq;
    import aes_defs::*;

    localparam int SBASE = 1;
    localparam int NOPKT = 4;

    localparam logic [127:0] ZERO = 128'h0;
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] IV1  = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] NIV1 = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
    localparam logic [127:0] D0   = 128'hDEADBEEF00112233445566778899AABB;
    localparam logic [127:0] D1   = 128'hCAFEF00D0123456789ABCDEF13579BDF;
    localparam logic [127:0] SENT = 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A00;
    localparam logic [127:0] HOLE = 128'h77777777777777777777777777777777;

    logic         clk = 1'b0;
    logic         rst;
    logic         AesIrdy;
    logic [1:0]   AesSize;
    logic         Sos;
    logic         AesBank;
    logic [1:0]   Cmd;
    logic [127:0] aes_iv;
    logic         AesTrdy;
    logic [2:0]   buf_addr;
    logic         buf_rd;
    logic [127:0] buf_rdata;
    logic         buf_wr;
    logic [127:0] buf_wdata;
    logic         core_irdy;
    logic [127:0] core_din;
    logic         core_trdy;
    logic         core_ovld;
    logic [127:0] core_dout;

    always #5 clk = ~clk;

    aes_cbc_seq #(.SBASE(SBASE), .NOPKT(NOPKT)) dut (
        .clk       (clk),
        .rst       (rst),
        .AesIrdy   (AesIrdy),
        .AesSize   (AesSize),
        .Sos       (Sos),
        .AesBank   (AesBank),
        .Cmd       (Cmd),
        .aes_iv    (aes_iv),
        .AesTrdy   (AesTrdy),
        .buf_addr  (buf_addr),
        .buf_rd    (buf_rd),
        .buf_rdata (buf_rdata),
        .buf_wr    (buf_wr),
        .buf_wdata (buf_wdata),
        .core_irdy (core_irdy),
        .core_din  (core_din),
        .core_trdy (core_trdy),
        .core_ovld (core_ovld),
        .core_dout (core_dout)
    );

    // Packet SRAM: one-cycle read latency; the bench preloads through tb_load.
    logic [127:0] mem [0:7];
    logic         tb_load;
    logic [2:0]   tb_addr;
    logic [127:0] tb_data;
    int           rd_cnt = 0;
    int           wr_cnt = 0;
    logic         rw_clash = 1'b0;

    always @(posedge clk) begin
        if (tb_load) mem[tb_addr] <= tb_data;
        else if (buf_wr) mem[buf_addr] <= buf_wdata;
        if (buf_rd) buf_rdata <= mem[buf_addr];
        if (buf_rd) rd_cnt <= rd_cnt + 1;
        if (buf_wr) wr_cnt <= wr_cnt + 1;
        if (buf_rd && buf_wr) rw_clash <= 1'b1;
    end

    // Core model: accepts one cycle after irdy, returns ~din three cycles later.
    logic         pend = 1'b0;
    int           lat_cnt = 0;
    logic [127:0] core_blk = '0;

    initial begin
        core_trdy = 1'b0;
        core_ovld = 1'b0;
        core_dout = '0;
    end

    always @(posedge clk) begin
        core_ovld <= 1'b0;
        if (rst) begin
            core_trdy <= 1'b0;
            pend      <= 1'b0;
        end else begin
            if (core_irdy && !core_trdy && !pend) begin
                core_trdy <= 1'b1;
            end else if (core_irdy && core_trdy) begin
                core_trdy <= 1'b0;
                pend      <= 1'b1;
                lat_cnt   <= 2;
                core_blk  <= core_din;
            end else begin
                core_trdy <= 1'b0;
            end
            if (pend) begin
                if (lat_cnt == 0) begin
                    core_ovld <= 1'b1;
                    core_dout <= core_blk ^ ONES;
                    pend      <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end
        end
    end

    int trdy_cnt = 0;
    int irdy_cnt = 0;

    always @(negedge clk) begin
        if (AesTrdy) trdy_cnt <= trdy_cnt + 1;
        if (core_irdy) irdy_cnt <= irdy_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load_word(input logic [2:0] a, input logic [127:0] d);
        @(negedge clk);
        tb_load = 1'b1;
        tb_addr = a;
        tb_data = d;
        @(negedge clk);
        tb_load = 1'b0;
    endtask

    // Raises AesIrdy with the given job and waits (bounded) for AesTrdy;
    // AesIrdy is left high for the caller to drop.
    task automatic applyStimulus(input logic [1:0] cmd, input logic [1:0] size, input logic bank,
                                 input logic sos, input logic [127:0] iv, output int lat);
        int n;
        @(negedge clk);
        Cmd     = cmd;
        AesSize = size;
        AesBank = bank;
        Sos     = sos;
        aes_iv  = iv;
        AesIrdy = 1'b1;
        n   = 0;
        lat = -1;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (AesTrdy) begin
                lat = n - 1;
                break;
            end
        end
        Sos = 1'b0;
        if (lat < 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL job_timeout: got no AesTrdy in 400 cycles, expected a pulse");
        end
    endtask

    typedef struct packed {
        logic [1:0]         cmd;
        logic [1:0]         size;
        logic               bank;
        logic               sos;
        logic [127:0]       iv;
        logic [3:0][127:0]  init;
        logic [3:0][127:0]  exp;
        logic [127:0]       exp_chain;
        logic               exp_core;
        logic [7:0]         exp_lat;
    } vec_t;

    vec_t vecs [6];
    vec_t v;
    int   lat;
    int   t0;
    int   i0;
    int   r1;
    int   w0;
    int   t1;
    logic found;

    initial begin
        // Word lists run pkt3..pkt0; exp_lat of 0 means latency is not checked.
        vecs[0] = {CMD_ENC, 2'd0, 1'b0, 1'b1, IV1, {ZERO, ZERO, ZERO, ZERO},
                   {ZERO, ZERO, ZERO, NIV1}, NIV1, 1'b1, 8'd0};
        vecs[1] = {2'b01, 2'd1, 1'b0, 1'b0, ZERO, {ZERO, ZERO, D1, D0},
                   {ZERO, ZERO, D1, D0}, NIV1, 1'b0, 8'd6};
        vecs[2] = {CMD_DEC, 2'd0, 1'b0, 1'b0, ZERO, {ZERO, ZERO, ZERO, ZERO},
                   {ZERO, ZERO, ZERO, IV1}, ZERO, 1'b1, 8'd0};
        vecs[3] = {CMD_ENC, 2'd3, 1'b1, 1'b1, ZERO, {ZERO, ZERO, ZERO, ZERO},
                   {ZERO, ONES, ZERO, ONES}, ZERO, 1'b1, 8'd0};
        vecs[4] = {CMD_DEC, 2'd3, 1'b1, 1'b1, ZERO, {ZERO, ONES, ZERO, ONES},
                   {ZERO, ZERO, ZERO, ZERO}, ZERO, 1'b1, 8'd0};
        vecs[5] = {CMD_DEC, 2'd3, 1'b1, 1'b0, 128'h1234, {ZERO, ONES, ZERO, ONES},
                   {ZERO, ZERO, ZERO, ZERO}, ZERO, 1'b1, 8'd0};

        rst     = 1'b1;
        AesIrdy = 1'b0;
        AesSize = 2'd0;
        Sos     = 1'b0;
        AesBank = 1'b0;
        Cmd     = 2'b00;
        aes_iv  = '0;
        tb_load = 1'b0;
        tb_addr = '0;
        tb_data = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_AesTrdy", 128'(AesTrdy), 128'd0);
        checkOutput("rst_buf_rd", 128'(buf_rd), 128'd0);
        checkOutput("rst_buf_wr", 128'(buf_wr), 128'd0);
        checkOutput("rst_core_irdy", 128'(core_irdy), 128'd0);
        checkOutput("rst_buf_addr", 128'(buf_addr), 128'd0);
        checkOutput("rst_buf_wdata", buf_wdata, ZERO);
        checkOutput("rst_core_din", core_din, ZERO);
        checkOutput("rst_chain", dut.u_chain.chain_q, ZERO);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            for (int w = 0; w < 4; w++) begin
                load_word({v.bank, 2'(w)}, v.init[w]);
                load_word({~v.bank, 2'(w)}, SENT ^ 128'(w));
            end
            t0 = trdy_cnt;
            i0 = irdy_cnt;
            applyStimulus(v.cmd, v.size, v.bank, v.sos, v.iv, lat);
            AesIrdy = 1'b0;
            repeat (3) @(negedge clk);
            for (int w = 0; w <= int'(v.size); w++)
                checkOutput($sformatf("v%0d_pkt%0d", i, w), mem[{v.bank, 2'(w)}], v.exp[w]);
            for (int w = 0; w < 4; w++)
                checkOutput($sformatf("v%0d_other%0d", i, w), mem[{~v.bank, 2'(w)}], SENT ^ 128'(w));
            checkOutput($sformatf("v%0d_trdy_pulses", i), 128'(trdy_cnt - t0), 128'd1);
            checkOutput($sformatf("v%0d_core_used", i), 128'(irdy_cnt != i0), 128'(v.exp_core));
            checkOutput($sformatf("v%0d_chain", i), dut.u_chain.chain_q, v.exp_chain);
            if (v.exp_lat != 8'd0)
                checkOutput($sformatf("v%0d_latency", i), 128'(lat), 128'(v.exp_lat));
        end

        // AesIrdy held high after AesTrdy must not start another job.
        load_word(3'd0, D0);
        applyStimulus(2'b00, 2'd0, 1'b0, 1'b0, ZERO, lat);
        @(negedge clk);
        r1 = rd_cnt;
        t1 = trdy_cnt;
        repeat (10) @(negedge clk);
        checkOutput("hold_no_reads", 128'(rd_cnt - r1), 128'd0);
        checkOutput("hold_no_trdy", 128'(trdy_cnt - t1), 128'd0);
        AesIrdy = 1'b0;
        @(negedge clk);
        load_word(3'd0, D1);
        t0 = trdy_cnt;
        applyStimulus(2'b00, 2'd0, 1'b0, 1'b0, ZERO, lat);
        AesIrdy = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rejob_trdy", 128'(trdy_cnt - t0), 128'd1);
        checkOutput("rejob_data", mem[0], D1);

        // Reset while the third packet of a 4-packet encrypt waits in COREOUT.
        load_word(3'd0, D0);
        load_word(3'd1, D1);
        load_word(3'd2, HOLE);
        load_word(3'd3, D1);
        w0 = wr_cnt;
        @(negedge clk);
        Cmd     = CMD_ENC;
        AesSize = 2'd3;
        AesBank = 1'b0;
        Sos     = 1'b1;
        aes_iv  = ZERO;
        AesIrdy = 1'b1;
        found   = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            Sos = 1'b0;
            if ((wr_cnt - w0) >= 2 && core_irdy && core_trdy) found = 1'b1;
        end
        checkOutput("rst_seq_reached_pkt2", 128'(found), 128'd1);
        @(negedge clk);
        checkOutput("rst_seq_in_coreout", 128'(dut.state_q), 128'(ST_COREOUT));
        rst     = 1'b1;
        AesIrdy = 1'b0;
        t0      = trdy_cnt;
        @(negedge clk);
        checkOutput("midrst_state", 128'(dut.state_q), 128'(ST_IDLE));
        checkOutput("midrst_core_irdy", 128'(core_irdy), 128'd0);
        checkOutput("midrst_AesTrdy", 128'(AesTrdy), 128'd0);
        checkOutput("midrst_buf_addr", 128'(buf_addr), 128'd0);
        checkOutput("midrst_core_din", core_din, ZERO);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("midrst_no_trdy", 128'(trdy_cnt - t0), 128'd0);
        checkOutput("midrst_pkt2_unwritten", mem[2], HOLE);

        load_word(3'd4, ZERO);
        t0 = trdy_cnt;
        applyStimulus(CMD_ENC, 2'd0, 1'b1, 1'b1, IV1, lat);
        AesIrdy = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("postrst_trdy", 128'(trdy_cnt - t0), 128'd1);
        checkOutput("postrst_data", mem[4], NIV1);
        checkOutput("postrst_chain", dut.u_chain.chain_q, NIV1);

        checkOutput("rd_wr_exclusive", 128'(rw_clash), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
